// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide engine.
// Latency: n/a (types, op codes and decode helpers only).
// Backpressure: n/a.
package muldiv_pkg;

    // Op code bit 0 set means the operands are treated as unsigned.
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;
    localparam logic [2:0] OP_MSUB  = 3'b110;
    localparam logic [2:0] OP_MSUBU = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_acc(input logic [2:0] op);
        return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_sub(input logic [2:0] op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_unsigned(input logic [2:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU) || (op == OP_MADDU) || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared shift/add datapath: one multiply or restoring-divide step per enabled cycle.
// Latency: one step per cycle with step=1; load takes effect on the next edge.
// Backpressure: none; the controller decides when load/step fire.
//   clk, reset    : clock, async active-low reset
//   load/loadDiv  : capture magnitudes and select multiply (0) or divide (1) mode
//   loadLo        : multiplier (mul) or dividend (div) magnitude, placed in the low half
//   loadAddend    : multiplicand (mul) or divisor (div) magnitude
//   step          : advance one iteration
//   acc           : {hi,lo} shift register contents
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 loadDiv,
    input  logic [WIDTH-1:0]     loadLo,
    input  logic [WIDTH-1:0]     loadAddend,
    output logic [2*WIDTH-1:0]   acc
);

    logic [2*WIDTH-1:0] shiftReg;
    logic [WIDTH-1:0]   addend;
    logic               divMode;

    logic [WIDTH-1:0]   hiPart;
    logic [WIDTH-1:0]   loPart;
    logic [WIDTH:0]     opX;
    logic [WIDTH:0]     opY;
    logic [WIDTH:0]     addOut;
    logic               fits;
    logic [2*WIDTH-1:0] stepVal;

    always_comb begin
        hiPart = shiftReg[2*WIDTH-1:WIDTH];
        loPart = shiftReg[WIDTH-1:0];
        // Divide works on the remainder shifted left by one with the next
        // dividend bit pulled in; multiply works on the plain high half.
        opX    = divMode ? {hiPart, loPart[WIDTH-1]} : {1'b0, hiPart};
        // Single adder: subtract in divide mode via invert plus carry-in.
        opY    = {1'b0, addend} ^ {(WIDTH+1){divMode}};
        addOut = opX + opY + {{WIDTH{1'b0}}, divMode};
        // The shifted remainder can carry into bit WIDTH; in that case it is
        // necessarily larger than any WIDTH-bit divisor.
        fits   = opX[WIDTH] | ~addOut[WIDTH];
        if (divMode) begin
            stepVal = {(fits ? addOut[WIDTH-1:0] : opX[WIDTH-1:0]), loPart[WIDTH-2:0], fits};
        end else begin
            // Carry out of the add becomes the new top bit as the pair shifts right.
            stepVal = {(loPart[0] ? addOut : opX), loPart[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shiftReg <= '0;
            addend   <= '0;
            divMode  <= 1'b0;
        end else if (load) begin
            shiftReg <= {{WIDTH{1'b0}}, loadLo};
            addend   <= loadAddend;
            divMode  <= loadDiv;
        end else if (step) begin
            shiftReg <= stepVal;
        end
    end

    assign acc = shiftReg;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply, divide and multiply-accumulate/subtract into {hi,lo}.
// Latency: WIDTH+1 edges from accepted start to ready; 1 edge for divide by zero.
// Backpressure: busy stalls the pipeline; start is ignored while busy, annul aborts ITER/FIX.
//   clk, reset          : clock, async active-low reset
//   start, annul, op    : launch / abort, op code (bit 0 = unsigned)
//   srca, srcb, hilo_i  : operands and accumulator, sampled on an accepted start
//   busy, ready, result : in flight, one-cycle completion pulse, held {hi,lo}
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 annul,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     srca,
    input  logic [WIDTH-1:0]     srcb,
    input  logic [2*WIDTH-1:0]   hilo_i,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    state_t             state;
    state_t             nextState;
    logic [CNT_W-1:0]   iterCnt;
    logic [2:0]         opReg;
    logic [2*WIDTH-1:0] hiloReg;
    logic               negRes;
    logic               negDividend;
    logic               divZero;

    logic               srcaNeg;
    logic               srcbNeg;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic               accept;
    logic               launchDiv;
    logic               launchDivZero;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] fixVal;

    assign srcaNeg       = ~is_unsigned(op) & srca[WIDTH-1];
    assign srcbNeg       = ~is_unsigned(op) & srcb[WIDTH-1];
    assign magA          = srcaNeg ? -srca : srca;
    assign magB          = srcbNeg ? -srcb : srcb;
    assign accept        = (state == IDLE) & start & ~annul;
    assign launchDiv     = is_div(op);
    assign launchDivZero = launchDiv & (srcb == '0);

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .step      (state == ITER),
        .loadDiv   (launchDiv),
        .loadLo    (launchDiv ? magA : magB),
        .loadAddend(launchDiv ? magB : magA),
        .acc       (acc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = launchDivZero ? FIX : ITER;
                end
            end
            ITER: begin
                if (annul) begin
                    nextState = IDLE;
                end else if (iterCnt == CNT_W'(WIDTH - 1)) begin
                    nextState = FIX;
                end
            end
            FIX: begin
                nextState = annul ? IDLE : DONE;
            end
            DONE: begin
                // Result is already committed, so annul has nothing to undo.
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Sign correction and accumulate, applied to the magnitude result.
    always_comb begin
        logic [WIDTH-1:0]   accLo;
        logic [WIDTH-1:0]   accHi;
        logic [WIDTH-1:0]   quot;
        logic [WIDTH-1:0]   rem;
        logic [WIDTH-1:0]   dividend;
        logic [2*WIDTH-1:0] prod;
        accLo    = acc[WIDTH-1:0];
        accHi    = acc[2*WIDTH-1:WIDTH];
        quot     = negRes ? -accLo : accLo;
        rem      = negDividend ? -accHi : accHi;
        // With no iterations run the low half still holds |srca|.
        dividend = negDividend ? -accLo : accLo;
        prod     = negRes ? -acc : acc;
        fixVal   = prod;
        if (is_div(opReg)) begin
            fixVal = divZero ? {dividend, {WIDTH{1'b1}}} : {rem, quot};
        end else if (is_acc(opReg)) begin
            fixVal = is_sub(opReg) ? (hiloReg - prod) : (hiloReg + prod);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iterCnt     <= '0;
            opReg       <= OP_MULT;
            hiloReg     <= '0;
            negRes      <= 1'b0;
            negDividend <= 1'b0;
            divZero     <= 1'b0;
            result      <= '0;
        end else begin
            if (accept) begin
                iterCnt     <= '0;
                opReg       <= op;
                hiloReg     <= hilo_i;
                negRes      <= srcaNeg ^ srcbNeg;
                negDividend <= srcaNeg;
                divZero     <= launchDivZero;
            end else if (state == ITER) begin
                iterCnt <= iterCnt + CNT_W'(1);
            end
            if ((state == FIX) && !annul) begin
                result <= fixVal;
            end
        end
    end

    assign busy  = (state != IDLE);
    assign ready = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus per-cycle output compare.
// Latency: expects ready WIDTH+1 edges after the start edge (1 for divide by zero).
// Backpressure: launches only after the previous operation has completed.
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic           clk    = 1'b0;
    logic           reset  = 1'b0;
    logic           start  = 1'b0;
    logic           annul  = 1'b0;
    logic [2:0]     op     = 3'd0;
    logic [W-1:0]   srca   = '0;
    logic [W-1:0]   srcb   = '0;
    logic [2*W-1:0] hilo_i = '0;
    logic           busy;
    logic           ready;
    logic [2*W-1:0] result;

    int errors = 0;
    int checks = 0;
    int edgeCnt = 0;

    // Expected-behaviour state: one operation in flight at most.
    bit          chkEn   = 1'b0;
    bit          mActive = 1'b0;
    int          mStart  = 0;
    int          mLat    = 0;
    logic [63:0] mExp    = '0;
    logic [63:0] mPrev   = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .annul (annul),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .hilo_i(hilo_i),
        .busy  (busy),
        .ready (ready),
        .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edgeCnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] h);
        longint la, lb, q, r;
        logic [63:0] p;
        la = o[0] ? longint'({32'b0, a}) : longint'($signed(a));
        lb = o[0] ? longint'({32'b0, b}) : longint'($signed(b));
        if (o[2:1] == 2'b01) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = la / lb;
            r = la % lb;
            return {r[31:0], q[31:0]};
        end
        p = la * lb;
        if (o[2]) return o[1] ? (h - p) : (h + p);
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare of busy/ready/result against the expected timeline.
    always @(negedge clk) begin
        logic        eb, er;
        logic [63:0] eres;
        int          k;
        if (chkEn) begin
            eb   = 1'b0;
            er   = 1'b0;
            eres = mPrev;
            if (mActive) begin
                k  = edgeCnt - mStart;
                eb = (k <= mLat);
                er = (k == mLat);
                if (k >= mLat) eres = mExp;
                if (k > mLat) begin
                    mPrev   = mExp;
                    mActive = 1'b0;
                end
            end
            check("cyc busy", {63'd0, busy}, {63'd0, eb});
            check("cyc ready", {63'd0, ready}, {63'd0, er});
            check("cyc result", result, eres);
        end
    end

    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] h);
        @(posedge clk); #1;
        op = o; srca = a; srcb = b; hilo_i = h; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        mExp    = model(o, a, b, h);
        mLat    = (o[2:1] == 2'b01 && b == 32'd0) ? 1 : LAT;
        mStart  = edgeCnt;
        mActive = 1'b1;
    endtask

    task automatic waitReady(input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: ready not seen within %0d cycles", name, n);
        end
    endtask

    task automatic runPinned(input string name, input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] h,
                             input logic [63:0] lit, input int lat);
        check({name, " model"}, model(o, a, b, h), lit);
        launch(o, a, b, h);
        waitReady(name);
        check({name, " latency"}, 64'(edgeCnt - mStart), 64'(lat));
        check({name, " result"}, result, lit);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic [63:0] rh;
        int          sel;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset ready", {63'd0, ready}, 64'd0);
        check("reset result", result, 64'd0);
        reset = 1'b1;
        chkEn = 1'b1;

        runPinned("mult -1x2", 3'b000, 32'hFFFF_FFFF, 32'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        runPinned("multu", 3'b001, 32'hFFFF_FFFF, 32'd2, 64'd0, 64'h0000_0001_FFFF_FFFE, 33);
        runPinned("div -7/2", 3'b010, 32'hFFFF_FFF9, 32'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        runPinned("divu 7/2", 3'b011, 32'd7, 32'd2, 64'd0, 64'h0000_0001_0000_0003, 33);
        runPinned("div minneg/-1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0,
                  64'h0000_0000_8000_0000, 33);
        runPinned("divu 5/0", 3'b011, 32'd5, 32'd0, 64'd0, 64'h0000_0005_FFFF_FFFF, 1);
        runPinned("div -5/0", 3'b010, 32'hFFFF_FFFB, 32'd0, 64'd0, 64'hFFFF_FFFB_FFFF_FFFF, 1);
        runPinned("madd", 3'b100, 32'd3, 32'd4, 64'h10, 64'h1C, 33);
        runPinned("msub", 3'b110, 32'd1, 32'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 33);

        // Annul ten cycles into a multiply: no ready, result unchanged.
        launch(3'b000, 32'h1234, 32'h5678, 64'd0);
        repeat (9) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        mActive = 1'b0;
        @(negedge clk);
        check("annul iter busy", {63'd0, busy}, 64'd0);
        check("annul iter result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (40) @(posedge clk);

        // Annul during FIX also discards the result.
        launch(3'b011, 32'd100, 32'd7, 64'd0);
        repeat (W) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        mActive = 1'b0;
        @(negedge clk);
        check("annul fix result", result, 64'hFFFF_FFFF_FFFF_FFFF);

        // Annul during DONE is ignored.
        launch(3'b011, 32'd100, 32'd7, 64'd0);
        repeat (W + 1) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        @(negedge clk);
        check("annul done result", result, 64'h0000_0002_0000_000E);

        // Start while busy is ignored.
        launch(3'b001, 32'd7, 32'd6, 64'd0);
        op = 3'b011; srca = 32'd100; srcb = 32'd0; start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        waitReady("start while busy");
        check("start while busy result", result, 64'd42);

        // Start together with annul in IDLE launches nothing.
        @(posedge clk); #1;
        @(posedge clk); #1;
        op = 3'b000; srca = 32'd3; srcb = 32'd3; start = 1'b1; annul = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        @(negedge clk);
        check("start+annul busy", {63'd0, busy}, 64'd0);
        repeat (5) @(posedge clk);

        // Reset mid-divide clears outputs at once.
        launch(3'b010, 32'd100, 32'd7, 64'd0);
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset busy", {63'd0, busy}, 64'd0);
        check("midreset ready", {63'd0, ready}, 64'd0);
        check("midreset result", result, 64'd0);
        mActive = 1'b0;
        mPrev   = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        runPinned("divu 9/3", 3'b011, 32'd9, 32'd3, 64'd0, 64'h0000_0000_0000_0003, 33);

        // Randomised operations with corner-biased operands.
        for (int i = 0; i < 60; i++) begin
            ro  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            rb  = $urandom;
            rh  = {$urandom, $urandom};
            case (sel)
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 20)) - 32'd10; rb = 32'($urandom_range(0, 6)) - 32'd3; end
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            launch(ro, ra, rb, rh);
            waitReady("random op");
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
